// File: rtl/turbo_frame_sched.sv
// Frame scheduler for the turbo constituent encoder: ping-pong nibble buffer
// feeding a serial data / tail / gap sequencer with valid-ready back-pressure.
module turbo_frame_sched #(
  parameter int NIB_PER_FRAME = 16,
  parameter int TAIL_LEN      = 3,
  parameter int GAP_LEN       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  nib_in,
  input  logic        nib_valid,
  output logic        nib_ready,
  output logic        enc_bit,
  output logic        enc_en,
  output logic        enc_sof,
  output logic        enc_eof,
  output logic        tail_en,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int FRAME_BITS = 4 * NIB_PER_FRAME;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int FILL_W     = $clog2(NIB_PER_FRAME);
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  logic [FRAME_BITS-1:0] bank_q [2];
  logic [1:0]            full_q, full_d;
  logic [FILL_W-1:0]     fill_cnt_q;
  logic                  wr_bank_q, rd_bank_q;
  logic [15:0]           frame_cnt_q;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic enc_bit_q, enc_bit_d;
  logic enc_en_q, enc_en_d;
  logic enc_sof_q, enc_sof_d;
  logic enc_eof_q, enc_eof_d;
  logic tail_en_q, tail_en_d;

  logic accept, fill_done, drain_done, start_ok;

  assign nib_ready  = ~full_q[wr_bank_q];
  assign accept     = nib_valid & nib_ready;
  assign fill_done  = accept & (fill_cnt_q == FILL_W'(NIB_PER_FRAME - 1));
  assign drain_done = (state_q == S_DATA) && (bit_idx_q == '0);
  assign start_ok   = full_q[rd_bank_q];

  // Fill and drain touch different banks, so both updates apply independently.
  always_comb begin
    full_d = full_q;
    if (drain_done) full_d[rd_bank_q] = 1'b0;
    if (fill_done)  full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) bank_q[b] <= '0;
      full_q      <= '0;
      fill_cnt_q  <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        bank_q[wr_bank_q] <= {bank_q[wr_bank_q][FRAME_BITS-5:0], nib_in};
        if (fill_done) begin
          fill_cnt_q <= '0;
          wr_bank_q  <= ~wr_bank_q;
        end else begin
          fill_cnt_q <= fill_cnt_q + FILL_W'(1);
        end
      end
      if (drain_done) begin
        rd_bank_q   <= ~rd_bank_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d   = S_DATA;
          bit_idx_d = IDX_W'(FRAME_BITS - 1);
        end
      end
      S_DATA: begin
        if (bit_idx_q == '0) begin
          state_d = S_TAIL;
          cnt_d   = CNT_W'(TAIL_LEN - 1);
        end else begin
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end
      S_TAIL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (GAP_LEN > 0) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_LEN - 1);
        end else if (start_ok) begin
          state_d   = S_DATA;
          bit_idx_d = IDX_W'(FRAME_BITS - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (start_ok) begin
          state_d   = S_DATA;
          bit_idx_d = IDX_W'(FRAME_BITS - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    enc_en_d  = (state_d == S_DATA);
    enc_bit_d = enc_en_d & bank_q[rd_bank_q][bit_idx_d];
    enc_sof_d = enc_en_d && (bit_idx_d == IDX_W'(FRAME_BITS - 1));
    enc_eof_d = enc_en_d && (bit_idx_d == '0);
    tail_en_d = (state_d == S_TAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_bit_q <= 1'b0;
      enc_en_q  <= 1'b0;
      enc_sof_q <= 1'b0;
      enc_eof_q <= 1'b0;
      tail_en_q <= 1'b0;
    end else begin
      enc_bit_q <= enc_bit_d;
      enc_en_q  <= enc_en_d;
      enc_sof_q <= enc_sof_d;
      enc_eof_q <= enc_eof_d;
      tail_en_q <= tail_en_d;
    end
  end

  assign enc_bit   = enc_bit_q;
  assign enc_en    = enc_en_q;
  assign enc_sof   = enc_sof_q;
  assign enc_eof   = enc_eof_q;
  assign tail_en   = tail_en_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (|full_q) | (fill_cnt_q != '0) | (state_q != S_IDLE);

endmodule

// File: tb/tb_turbo_frame_sched.sv
// Scoreboard bench: two scheduler instances (tail 3 / gap 2 and tail 4 / gap 0)
// checked against a frame-level timing model of the sequencer.
module tb_turbo_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit done [2];

  typedef struct {
    logic [63:0] data;
    int          a;
    int          sof;
    int          num;
  } frame_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] pick(input int mode, input int i);
    case (mode)
      0:       return 4'(i % 16);
      1:       return 4'hF;
      default: return 4'($urandom);
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int T = (gi == 0) ? 3 : 4;
    localparam int G = (gi == 0) ? 2 : 0;
    localparam int P = 64 + T + G;

    logic        rst;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        nib_ready, enc_bit, enc_en, enc_sof, enc_eof, tail_en, busy;
    logic [15:0] frame_cnt;

    turbo_frame_sched #(.NIB_PER_FRAME(16), .TAIL_LEN(T), .GAP_LEN(G)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .nib_in    (nib_in),
      .nib_valid (nib_valid),
      .nib_ready (nib_ready),
      .enc_bit   (enc_bit),
      .enc_en    (enc_en),
      .enc_sof   (enc_sof),
      .enc_eof   (enc_eof),
      .tail_en   (tail_en),
      .busy      (busy),
      .frame_cnt (frame_cnt)
    );

    frame_t      exp_q [$];
    frame_t      hist [$];
    int          fill = 0;
    logic [63:0] word = '0;
    int          last_sof = -1000;
    bit          armed = 1'b0;

    function automatic string nm(input string s);
      return $sformatf("u%0d.%s", gi, s);
    endfunction

    // Expected handshake/status from the frame schedule: a bank is held from
    // its fill edge until the edge after eof; the sequencer runs sof..sof+P-1.
    task automatic check_cycle();
      int c, nfull, ndone;
      bit run;
      c = int'(cyc);
      nfull = 0;
      ndone = 0;
      run = 1'b0;
      foreach (hist[k]) begin
        if (hist[k].a <= c && c < hist[k].sof + 64) nfull++;
        if (hist[k].sof + 64 <= c) ndone++;
        if (hist[k].a <= c && c <= hist[k].sof + P - 1) run = 1'b1;
      end
      chk(nm("ready"), 64'(nib_ready), 64'(nfull < 2));
      chk(nm("busy"), 64'(busy), 64'(run || fill != 0));
      chk(nm("frame_cnt_live"), 64'(frame_cnt), 64'(ndone % 65536));
    endtask

    task automatic step(input bit v, input logic [3:0] d, output bit acc);
      int c;
      frame_t f;
      c = int'(cyc);
      check_cycle();
      nib_valid = v;
      nib_in    = d;
      acc = v && (nib_ready === 1'b1);
      if (acc) begin
        word = {word[59:0], d};
        fill++;
        if (fill == 16) begin
          f.data = word;
          f.a    = c + 1;
          f.sof  = (c + 2 > last_sof + P) ? c + 2 : last_sof + P;
          f.num  = hist.size() + 1;
          hist.push_back(f);
          exp_q.push_back(f);
          last_sof = f.sof;
          fill = 0;
        end
      end
      @(negedge clk);
    endtask

    task automatic send(input int n, input int vmode, input int dmode);
      int got, guard;
      bit acc, v;
      logic [3:0] d;
      got = 0;
      guard = 0;
      d = pick(dmode, 0);
      while (got < n && guard < 4000) begin
        case (vmode)
          0:       v = 1'b1;
          1:       v = (guard % 2 == 0);
          default: v = ($urandom_range(0, 3) != 0);
        endcase
        step(v, d, acc);
        if (acc) begin
          got++;
          d = pick(dmode, got);
        end
        guard++;
      end
      chk(nm("send_done"), 64'(got), 64'(n));
    endtask

    task automatic idle_until(input int target);
      bit acc;
      while (int'(cyc) < target) step(1'b0, 4'h0, acc);
    endtask

    task automatic drain();
      idle_until(last_sof + P + 3);
    endtask

    task automatic do_reset(input int n);
      armed     = 1'b1;
      rst       = 1'b1;
      nib_valid = 1'b0;
      exp_q.delete();
      hist.delete();
      fill     = 0;
      word     = '0;
      last_sof = -1000;
      repeat (n) @(negedge clk);
      rst = 1'b0;
    endtask

    initial begin
      rst       = 1'b0;
      nib_valid = 1'b0;
      nib_in    = 4'h0;
      @(negedge clk);
      do_reset(2);
      send(16, 0, 0); drain();
      send(48, 0, 0); drain();
      send(16, 1, 0); drain();
      // Abort a frame while bit index 20 is on the wire, then refill.
      send(16, 0, 0);
      idle_until(last_sof + 43);
      do_reset(1);
      send(16, 0, 0); drain();
      send(16, 0, 1); drain();
      send(64, 2, 2); drain();
      send(48, 0, 2); drain();
      done[gi] = 1'b1;
    end

    // Monitor: pops the scoreboard at each sof and follows the frame through its tail.
    initial begin
      frame_t      cur;
      bit          active, bad;
      int          pos;
      logic [63:0] got_w;
      active = 1'b0;
      bad    = 1'b0;
      pos    = 0;
      got_w  = '0;
      forever begin
        @(posedge clk);
        #1;
        if (armed) begin
          if (rst) begin
            chk(nm("rst_outs"), 64'({enc_bit, enc_en, enc_sof, enc_eof, tail_en, busy}), 64'(0));
            chk(nm("rst_ready"), 64'(nib_ready), 64'(1));
            chk(nm("rst_cnt"), 64'(frame_cnt), 64'(0));
            active = 1'b0;
          end else begin
            if (!active) begin
              if (enc_sof) begin
                chk(nm("sof_expected"), 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                  cur = exp_q.pop_front();
                  chk(nm("sof_cycle"), 64'(cyc), 64'(cur.sof));
                  active = 1'b1;
                  pos    = 0;
                  got_w  = '0;
                  bad    = 1'b0;
                end
              end else begin
                chk(nm("idle_outs"), 64'({enc_bit, enc_en, enc_eof, tail_en}), 64'(0));
              end
            end
            if (active) begin
              if (pos < 64) begin
                got_w = {got_w[62:0], enc_bit};
                if (enc_en !== 1'b1 || tail_en !== 1'b0 ||
                    enc_sof !== (pos == 0) || enc_eof !== (pos == 63)) bad = 1'b1;
                if (pos == 63) begin
                  chk(nm("frame_data"), got_w, cur.data);
                  chk(nm("data_strobes"), 64'(bad), 64'(0));
                  bad = 1'b0;
                end
              end else begin
                if (tail_en !== 1'b1 || enc_en !== 1'b0 || enc_bit !== 1'b0 ||
                    enc_sof !== 1'b0 || enc_eof !== 1'b0) bad = 1'b1;
                if (pos == 64) chk(nm("frame_cnt"), 64'(frame_cnt), 64'(cur.num));
                if (pos == 63 + T) begin
                  chk(nm("tail_phase"), 64'(bad), 64'(0));
                  active = 1'b0;
                end
              end
              pos++;
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(done[0] && done[1]) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk("completion", 64'(done[0] && done[1]), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turbo_frame_sched.md
Name: turbo_frame_sched

Overview:
Frame scheduler/controller in front of the turbo constituent encoder.
- Accepts 4-bit symbols from upstream with a valid/ready handshake.
- Assembles 64-bit frames in a two-bank ping-pong buffer.
- Sequences each frame to the encoder as a serial bit stream with start/end strobes, trellis-termination (tail) cycles and an inter-frame gap.
- Replaces free-running fill/serialize timing with explicit flow control, so no input is lost while a frame drains.

Parameters:
NIB_PER_FRAME, 16, nibbles per frame; frame = 4*NIB_PER_FRAME bits; fixed at 16 in this revision.
TAIL_LEN, 3, tail_en cycles after each frame; legal range 1..7.
GAP_LEN, 2, idle cycles after the tail before the next frame; legal range 0..7.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
nib_in  input  4  data nibble
nib_valid  input  1  nib_in valid
nib_ready  output  1  nibble accepted on an edge where nib_valid & nib_ready
enc_bit  output  1  serial data bit to the encoder
enc_en  output  1  enc_bit valid (data phase only)
enc_sof  output  1  high with the first data bit of a frame
enc_eof  output  1  high with the last (64th) data bit of a frame
tail_en  output  1  termination phase; encoder flushes its own state
busy  output  1  high when any bank is full or partially filled, or the FSM is not IDLE
frame_cnt  output  16  frames completed; increments on the enc_eof cycle, wraps 0xFFFF->0

Behaviour:
- Reset: one clock, synchronous, active-high. Sampled high on an edge, it clears:
  - banks, full[1:0], fill count, wr_bank, rd_bank, FSM (to IDLE), frame_cnt
  - all outputs to 0, except nib_ready = 1 after the reset edge.
  - Reset mid-frame discards all partial and full frames; no eof or frame_cnt increment.
- Fill side:
  - nib_ready = !full[wr_bank].
  - On accept: bank[wr_bank] <= {bank[wr_bank][59:0], nib_in}; fill count increments.
  - On the 16th accept, the same edge sets full[wr_bank], toggles wr_bank and clears the fill count.
  - nib_valid while nib_ready is low: nothing is accepted. Upstream holds its data.
- Serialization order: bit 63 first, bit 0 last, i.e. first nibble's MSB first.
- FSM states: IDLE, DATA, TAIL, GAP.
  - IDLE: if full[rd_bank], go to DATA. The first data bit is registered on that same edge, so enc_sof/enc_en are visible one cycle after the edge that set full. Minimum latency from the 16th accept edge to sof is 1 cycle.
  - DATA: 64 cycles, bit index 63..0; enc_en = 1 throughout; enc_sof on index 63; enc_eof on index 0.
    - The edge leaving index 0 clears full[rd_bank], toggles rd_bank, increments frame_cnt and enters TAIL.
    - A nibble may be accepted into the freed bank from the following cycle.
  - TAIL: TAIL_LEN cycles with tail_en = 1, enc_en = 0, enc_bit = 0.
    - Then go to GAP, or, if GAP_LEN = 0, apply the IDLE decision directly.
  - GAP: GAP_LEN cycles, all encoder outputs 0. Then, if full[rd_bank], go directly to DATA (same rule as IDLE); else go to IDLE.
- Outputs are registered. enc_bit = 0 whenever enc_en = 0.
- Simultaneous fill-complete and drain-complete on different banks in the same cycle are both honoured; the banks are independent.
- Fill never overwrites a full bank.
- Back-to-back sof spacing is 64 + TAIL_LEN + GAP_LEN cycles when input keeps up.
- With both banks full, nib_ready stays low until the current frame's eof edge.

Test Plan:
1. rst high 2 cycles, then nibbles 0x0..0xF on 16 consecutive cycles:
   - enc_sof 1 cycle after the 16th accept edge.
   - enc_bit sequence 0000 0001 0010 ... 1111 with enc_en high 64 cycles; enc_eof on the 64th bit.
   - tail_en high 3 cycles, then 2 idle cycles; frame_cnt = 1; busy low after the gap.
2. 48 nibbles offered continuously:
   - nib_ready drops after 32 accepts and rises the cycle after frame 0's enc_eof.
   - sof-to-sof spacing = 69 cycles; frame_cnt = 3 at the end; data matches input order.
3. nib_valid toggling every other cycle for one frame: same 64-bit content as scenario 1; sof exactly 1 cycle after the 16th accept.
4. rst pulsed 1 cycle while enc_bit index = 20:
   - Next cycle all outputs are 0, nib_ready = 1, frame_cnt = 0, busy = 0.
   - No eof is produced; a new 16-nibble frame afterwards serializes correctly.
5. 16 x 0xF: 64 ones with enc_en high, then tail_en high 3 cycles with enc_bit = 0 and enc_en = 0.
6. TAIL_LEN = 4, GAP_LEN = 0, continuous input: tail_en high 4 cycles; sof spacing = 68 cycles; the next frame's sof immediately follows the last tail cycle.
